// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, response and memory-side signals of the
// shared line-memory arbiter, with master (requesters/memory) and slave (arbiter) views.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
);
    logic                  ic_req;
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic                  ic_ack;
    logic                  dc_req;
    logic                  dc_wr;
    logic [ADDR_WIDTH-1:0] dc_addr;
    logic [DATA_WIDTH-1:0] dc_wdata;
    logic                  dc_ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  mem_rd_wr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_wr;
    logic [DATA_WIDTH-1:0] mem_data_rd;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, mem_data_rd,
        output ic_ack, dc_ack, rdata, busy, mem_rd_wr, mem_we, mem_addr, mem_data_wr
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, mem_data_rd,
        input  ic_ack, dc_ack, rdata, busy, mem_rd_wr, mem_we, mem_addr, mem_data_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants icache (port 0) / dcache (port 1) line accesses to one memory port.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is dcache-wins fixed priority.
module mem_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LAT    = 4
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [7:0] LAT_M1 = 8'(MEM_LAT - 1);

    logic [1:0]            r_state;
    logic [7:0]            r_cnt;
    logic                  r_gnt;
    logic                  r_mem_wr;
    logic                  r_ic_ack;
    logic                  r_dc_ack;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data_wr;

    logic w_any;
    logic w_win;

    assign w_any = bus.ic_req | bus.dc_req;

`ifdef MEM_ARB_RR_EN
    logic r_ptr;
    logic w_tie;

    assign w_tie = bus.ic_req & bus.dc_req;
    assign w_win = w_tie ? ~r_ptr : bus.dc_req;

    // Remember the last granted port so the other one wins the next tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= w_win;
        end
    end
`else
    assign w_win = bus.dc_req;
`endif

    // Grant, hold the memory controls for MEM_LAT cycles, then pulse the ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_gnt         <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_ic_ack      <= 1'b0;
            r_dc_ack      <= 1'b0;
            r_rdata       <= '0;
            r_mem_addr    <= '0;
            r_mem_data_wr <= '0;
        end else begin
            r_ic_ack <= 1'b0;
            r_dc_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt    <= w_win;
                        r_cnt    <= LAT_M1;
                        r_mem_wr <= w_win & bus.dc_wr;
                        r_state  <= S_BUSY;
                        if (w_win) begin
                            r_mem_addr    <= bus.dc_addr;
                            r_mem_data_wr <= bus.dc_wdata;
                        end else begin
                            r_mem_addr <= bus.ic_addr;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 8'd0) begin
                        if (!r_mem_wr) begin
                            r_rdata <= bus.mem_data_rd;
                        end
                        r_mem_wr <= 1'b0;
                        r_ic_ack <= ~r_gnt;
                        r_dc_ack <= r_gnt;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ic_ack      = r_ic_ack;
    assign bus.dc_ack      = r_dc_ack;
    assign bus.rdata       = r_rdata;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.mem_rd_wr   = r_mem_wr;
    assign bus.mem_we      = r_mem_wr;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_data_wr = r_mem_data_wr;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for the shared 128-bit line memory of the pipelined processor. Two cache-miss requesters share the single memory port: the instruction cache on port 0 (line reads only) and the data cache on port 1 (line reads and write-backs). The block grants one request at a time and holds the memory controls stable for a fixed access latency. It then returns the line and a one-cycle acknowledge to the granted requester.

## Interface
- DATA_WIDTH, 128, line width in bits
- ADDR_WIDTH, 32, byte address width
- MEM_LAT, 4, cycles the memory controls are held per access; legal range 2..255

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- ic_req  in  1  icache read request; held high until ic_ack
- ic_addr  in  ADDR_WIDTH  icache line address; stable while ic_req
- ic_ack  out  1  one-cycle pulse: ic_rdata valid
- dc_req  in  1  dcache request; held high until dc_ack
- dc_wr  in  1  1 = write-back, 0 = line read; stable while dc_req
- dc_addr  in  ADDR_WIDTH  dcache line address
- dc_wdata  in  DATA_WIDTH  write-back line
- dc_ack  out  1  one-cycle pulse: read data valid or write done
- rdata  out  DATA_WIDTH  returned line, shared by both ports
- busy  out  1  high in BUSY and RESP
- mem_rd_wr  out  1  to memory; 0 = read, 1 = write
- mem_we  out  1  to memory write enable
- mem_addr  out  ADDR_WIDTH  to memory address
- mem_data_wr  out  DATA_WIDTH  to memory write data
- mem_data_rd  in  DATA_WIDTH  from memory read data

## Operation
The FSM has three states: IDLE, BUSY and RESP.

- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise select a winner (see Configuration).
  - Latch the winner's addr, wr and wdata into the memory output registers; port 0 is always latched with wr=0.
  - Record the winner in `gnt`, load `cnt = MEM_LAT-1`, and go to BUSY.
- **BUSY**
  - Memory outputs are held constant.
  - mem_rd_wr = mem_we = latched wr.
  - `cnt` decrements each cycle.
  - When `cnt == 0`: if the access is a read, capture mem_data_rd into rdata; then go to RESP.
- **RESP**
  - Assert the ack of port `gnt` for exactly one cycle.
  - Deassert mem_rd_wr and mem_we.
  - Go to IDLE.
  - Requests are not sampled in RESP; the acked requester drops req on the following edge.
- **Write accesses** leave rdata unchanged.
- **Held requests:** a request that is pending but not granted stays pending. It is granted in a later IDLE cycle.
- **Idle outputs:** mem_rd_wr=0 and mem_we=0. mem_addr and mem_data_wr hold their last values.
- **Reset values:**
  - ic_ack=0, dc_ack=0, busy=0
  - rdata=0, mem_rd_wr=0, mem_we=0, mem_addr=0, mem_data_wr=0
  - state=IDLE, cnt=0, gnt=0, round-robin pointer=0
- **Reset mid-access:** abort immediately and issue no ack. The memory line targeted by an in-flight write is undefined, and the requester must reissue the request.
- **Counter width:** 8 bits; MEM_LAT values outside 2..255 are unsupported.

## Timing
- Request sampled in IDLE at cycle G:
  - memory controls valid G+1 .. G+MEM_LAT
  - rdata is loaded at the end of cycle G+MEM_LAT and is valid from G+MEM_LAT+1
  - ack is high in cycle G+MEM_LAT+1
  - IDLE again at G+MEM_LAT+2
- Back-to-back occupancy is MEM_LAT+2 cycles per access.
- rdata is held until the next read completes.
- ic_ack and dc_ack are never high in the same cycle.
- busy is low in IDLE, including the IDLE cycle in which a grant is made.

## Configuration
Macro `MEM_ARB_RR_EN` selects the tie-break policy, applied when ic_req and dc_req are both high in IDLE.

- **Defined:** round-robin.
  - A 1-bit pointer records the last granted port.
  - On a tie, the port other than the pointer wins.
  - The pointer is updated on every grant.
  - Reset value 0, so the first tie goes to dcache.
- **Undefined:** fixed priority; the dcache always wins ties.
  - No pointer register.
  - An icache request waits while dc_req stays asserted.
- A single request with no tie is granted immediately under either policy.

## Test plan
All scenarios use MEM_LAT=4.
- **Icache read:** ic_req at G with ic_addr=0x40 and memory line 4 = 0xA5A5… → mem_addr=0x40 and mem_rd_wr=0 in G+1..G+4; ic_ack in G+5 with rdata=0xA5A5…; dc_ack=0 throughout.
- **Dcache write then read:** dc_wr=1, dc_addr=0x80, dc_wdata=0x1234 → mem_we=1 in G+1..G+4, dc_ack in G+5, rdata unchanged. A following read of 0x80 returns 0x1234.
- **Simultaneous requests:** ic_req and dc_req in the same cycle.
  - With MEM_ARB_RR_EN: dcache is granted first, then icache in the next IDLE cycle, and the order alternates on repeated ties.
  - Without it: dcache wins every tie.
- **Icache starvation check:** dc_req held continuously with ic_req high.
  - With MEM_ARB_RR_EN: ic_ack arrives no later than the second grant.
  - Without it: no ic_ack while dc_req stays high.
- **Reset mid-write:** reset asserted at G+2 of a write → all outputs zero immediately, no ack, state IDLE. A new request after reset is acked at G'+5.
- **Back-to-back reads:** continuous alternating requests → acks spaced exactly 6 cycles apart, never two acks in the same cycle.
